// File: rtl/load_use_stall_ctrl.sv
// load_use_stall_ctrl: load-use hazard and memory-wait stall controller.
// Optional STALL_PERF_CNT_EN macro adds the stall_count bubble counter.
module load_use_stall_ctrl #(
    parameter int REG_W             = 5,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             mem_busy,
    output logic             stall,
    output logic             bubble,
`ifdef STALL_PERF_CNT_EN
    output logic             freeze,
    output logic [CNT_W-1:0] stall_count
`else
    output logic             freeze
`endif
);
    typedef enum logic [1:0] {RST, IDLE, LSTALL} state_t;
    state_t     state_q, state_d;
    logic [3:0] remain_q, remain_d;
    logic       hazard;
    assign hazard = ex_mem_read && (ex_rt != '0) &&
                    ((id_use_rs && id_rs == ex_rt) || (id_use_rt && id_rt == ex_rt));
    // Outputs and next state; bubble is masked while reset is held so RST shows stall only.
    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        stall    = 1'b0;
        bubble   = 1'b0;
        freeze   = 1'b0;
        case (state_q)
            RST: begin
                stall   = 1'b1;
                bubble  = ~reset;
                state_d = IDLE;
            end
            IDLE: begin
                if (mem_busy) begin
                    stall  = 1'b1;
                    freeze = 1'b1;
                end else if (hazard) begin
                    stall  = 1'b1;
                    bubble = 1'b1;
                    if (LOAD_STALL_CYCLES > 1) begin
                        state_d  = LSTALL;
                        remain_d = 4'(LOAD_STALL_CYCLES - 1);
                    end
                end
            end
            LSTALL: begin
                if (mem_busy) begin
                    stall  = 1'b1;
                    freeze = 1'b1;
                end else begin
                    stall    = 1'b1;
                    bubble   = 1'b1;
                    remain_d = remain_q - 4'd1;
                    state_d  = (remain_q == 4'd1) ? IDLE : LSTALL;
                end
            end
            default: state_d = RST;
        endcase
    end
    // State and remaining-bubble registers; reset aborts any stall in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= RST;
            remain_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
        end
    end
`ifdef STALL_PERF_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Saturating count of load-use bubble cycles, excluding the post-reset flush.
    always_comb cnt_d = (bubble && state_q != RST && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
    // Counter register, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
    assign stall_count = cnt_q;
`endif
endmodule

// File: tb/tb_load_use_stall_ctrl.sv
// tb_load_use_stall_ctrl: directed checks of the stall controller at depths 1, 3 and 4.
module tb_load_use_stall_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ex_mem_read = 1'b0, id_use_rs = 1'b0, id_use_rt = 1'b0, mem_busy = 1'b0;
    logic [4:0] ex_rt = '0, id_rs = '0, id_rt = '0;
    logic       s1, b1, f1, s3, b3, f3, s4, b4, f4;
    int         checks = 0, errors = 0;
`ifdef STALL_PERF_CNT_EN
    logic [31:0] c1, c3, c4;
`endif

    always #5 clk = ~clk;

    load_use_stall_ctrl #(.REG_W(5), .LOAD_STALL_CYCLES(1), .CNT_W(32)) u1 (
        .clk(clk), .reset(reset), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .id_rs(id_rs),
        .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .mem_busy(mem_busy),
`ifdef STALL_PERF_CNT_EN
        .stall_count(c1),
`endif
        .stall(s1), .bubble(b1), .freeze(f1));
    load_use_stall_ctrl #(.REG_W(5), .LOAD_STALL_CYCLES(3), .CNT_W(32)) u3 (
        .clk(clk), .reset(reset), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .id_rs(id_rs),
        .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .mem_busy(mem_busy),
`ifdef STALL_PERF_CNT_EN
        .stall_count(c3),
`endif
        .stall(s3), .bubble(b3), .freeze(f3));
    load_use_stall_ctrl #(.REG_W(5), .LOAD_STALL_CYCLES(4), .CNT_W(32)) u4 (
        .clk(clk), .reset(reset), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .id_rs(id_rs),
        .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .mem_busy(mem_busy),
`ifdef STALL_PERF_CNT_EN
        .stall_count(c4),
`endif
        .stall(s4), .bubble(b4), .freeze(f4));

    task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: {stall,bubble,freeze} observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic chkc(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: stall_count observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic rd, input logic [4:0] rt, input logic [4:0] rs,
                          input logic [4:0] idrt, input logic urs, input logic urt, input logic mb);
        ex_mem_read = rd; ex_rt = rt; id_rs = rs; id_rt = idrt;
        id_use_rs = urs; id_use_rt = urt; mem_busy = mb;
        #2;
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        // reset held three cycles
        repeat (3) tick();
        chk("rst_hold_d1", {s1, b1, f1}, 3'b100);
        chk("rst_hold_d3", {s3, b3, f3}, 3'b100);
        chk("rst_hold_d4", {s4, b4, f4}, 3'b100);
        reset = 1'b0;
        #1;
        chk("flush_d1", {s1, b1, f1}, 3'b110);
        chk("flush_d4", {s4, b4, f4}, 3'b110);
        tick();
        chk("idle_d1", {s1, b1, f1}, 3'b000);
        chk("idle_d3", {s3, b3, f3}, 3'b000);
        // single hazard, depth 1
        set_in(1, 5, 5, 0, 1, 0, 0);
        chk("haz_d1", {s1, b1, f1}, 3'b110);
        tick();
        set_in(0, 5, 5, 0, 1, 0, 0);
        chk("haz_after_d1", {s1, b1, f1}, 3'b000);
`ifdef STALL_PERF_CNT_EN
        chkc("cnt_d1", c1, 32'd1);
`endif
        // false-hazard filtering and rt positive case
        set_in(1, 0, 0, 0, 1, 0, 0);
        chk("r0_excl_d1", {s1, b1, f1}, 3'b000);
        set_in(1, 7, 0, 7, 0, 0, 0);
        chk("rt_unused_d1", {s1, b1, f1}, 3'b000);
        set_in(1, 7, 0, 7, 0, 1, 0);
        chk("rt_used_d1", {s1, b1, f1}, 3'b110);
        set_in(1, 7, 0, 7, 0, 1, 1);
        chk("busy_over_haz_d1", {s1, b1, f1}, 3'b101);
        // depth 3 with a freeze inside the stall
        do_reset();
        chk("flush2_d3", {s3, b3, f3}, 3'b110);
        tick();
        set_in(1, 5, 5, 0, 1, 0, 0);
        chk("c0_d3", {s3, b3, f3}, 3'b110);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 1);
        chk("c1_freeze_d3", {s3, b3, f3}, 3'b101);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0);
        chk("c2_d3", {s3, b3, f3}, 3'b110);
        tick();
        chk("c3_d3", {s3, b3, f3}, 3'b110);
        tick();
        chk("c4_idle_d3", {s3, b3, f3}, 3'b000);
`ifdef STALL_PERF_CNT_EN
        chkc("cnt_d3", c3, 32'd3);
`endif
        set_in(1, 9, 0, 9, 0, 1, 0);
        chk("rehaz_d3", {s3, b3, f3}, 3'b110);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0);
        chk("rehaz_c1_d3", {s3, b3, f3}, 3'b110);
        // depth 4, reset during second bubble
        do_reset();
        chk("flush3_d4", {s4, b4, f4}, 3'b110);
        tick();
        set_in(1, 3, 3, 0, 1, 0, 0);
        chk("c0_d4", {s4, b4, f4}, 3'b110);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0);
        chk("c1_d4", {s4, b4, f4}, 3'b110);
        reset = 1'b1;
        #1;
        chk("async_rst_d4", {s4, b4, f4}, 3'b100);
`ifdef STALL_PERF_CNT_EN
        chkc("cnt_async_d4", c4, 32'd0);
`endif
        tick();
        reset = 1'b0;
        #1;
        chk("flush4_d4", {s4, b4, f4}, 3'b110);
        tick();
        chk("post_rst_idle_d4", {s4, b4, f4}, 3'b000);
        tick();
        chk("no_leftover_d4", {s4, b4, f4}, 3'b000);
`ifdef STALL_PERF_CNT_EN
        chkc("cnt_end_d4", c4, 32'd0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
